// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: FSM state encoding (common to TX and RX), widths,
// minimum bit period and the even-parity helper.
package rs232_pkg;

  localparam int DATA_W = 8;
  localparam int BAUD_W = 15;
  localparam logic [BAUD_W-1:0] MIN_BIT_PERIOD = 15'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rs232_state_e;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/baud_gen_tx.sv
// Bit-period timer for the transmitter: restart zeroes the count and latches the
// period (baud_i clamped to at least 2); tick_o marks the last cycle of each bit.
module baud_gen_tx
  import rs232_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              restart_i,
  input  logic [BAUD_W-1:0] baud_i,
  output logic              tick_o
);

  logic [BAUD_W-1:0] r_period;
  logic [BAUD_W-1:0] r_cnt;
  logic [BAUD_W-1:0] w_period_in;

  // Clamp the requested period to the minimum.
  always_comb begin
    if (baud_i < MIN_BIT_PERIOD) begin
      w_period_in = MIN_BIT_PERIOD;
    end else begin
      w_period_in = baud_i;
    end
  end

  assign tick_o = (r_cnt == (r_period - 15'd1));

  // Period latch and cycle counter.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_period <= MIN_BIT_PERIOD;
      r_cnt    <= 15'd0;
    end else if (restart_i) begin
      r_period <= w_period_in;
      r_cnt    <= 15'd0;
    end else if (tick_o) begin
      r_cnt    <= 15'd0;
    end else begin
      r_cnt    <= r_cnt + 15'd1;
    end
  end

endmodule

// File: rtl/rs232_tx.sv
// RS-232 transmitter: one-entry holding buffer, framing FSM, shift register, parity.
// Define RS232_TX_TWO_STOP_EN to stretch the stop bit to two bit periods.
module rs232_tx
  import rs232_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BAUD_W-1:0] baud_i,
  input  logic              psel_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              eot_o
);

  rs232_state_e      r_state, w_state_nxt;
  logic              r_tx, w_tx_nxt;
  logic              r_busy;
  logic              r_eot, w_eot_nxt;
  logic              r_ready;
  logic              r_full, w_full_nxt;
  logic [DATA_W-1:0] r_buf_data;
  logic              r_buf_psel;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [2:0]        r_bitcnt, w_bitcnt_nxt;
  logic              r_psel_frame;
  logic              r_par;
  logic              r_stop_half, w_stop_half_nxt;
  logic              w_frame_end;
  logic              w_load;
  logic              w_tick;
  logic              w_accept;

  assign ready_o  = r_ready;
  assign tx_o     = r_tx;
  assign busy_o   = r_busy;
  assign eot_o    = r_eot;
  assign w_accept = valid_i & r_ready;

  baud_gen_tx u_baud (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (w_load),
    .baud_i    (baud_i),
    .tick_o    (w_tick)
  );

  // Next-state, next-line-level and shifter logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_tx_nxt        = r_tx;
    w_shift_nxt     = r_shift;
    w_bitcnt_nxt    = r_bitcnt;
    w_stop_half_nxt = r_stop_half;
    w_frame_end     = 1'b0;
    w_load          = 1'b0;
    w_eot_nxt       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_full) begin
          w_load = 1'b1;
        end else begin
          w_tx_nxt = 1'b1;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt = ST_DATA;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_tx_nxt    = 1'b0;
        end
      end
      ST_DATA: begin
        if (w_tick && (r_bitcnt == 3'd7)) begin
          if (r_psel_frame) begin
            w_state_nxt = ST_PARITY;
            w_tx_nxt    = r_par;
          end else begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end
        end else if (w_tick) begin
          w_shift_nxt  = {1'b1, r_shift[DATA_W-1:1]};
          w_tx_nxt     = r_shift[1];
          w_bitcnt_nxt = r_bitcnt + 3'd1;
        end else begin
          w_tx_nxt     = r_tx;
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_state_nxt = ST_STOP;
          w_tx_nxt    = 1'b1;
        end else begin
          w_tx_nxt    = r_tx;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
`ifdef RS232_TX_TWO_STOP_EN
          if (r_stop_half) begin
            w_frame_end = 1'b1;
          end else begin
            w_stop_half_nxt = 1'b1;
          end
`else
          w_frame_end = 1'b1;
`endif
        end else begin
          w_frame_end = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // Frame end either chains straight into the next start bit or drops to idle.
    if (w_frame_end) begin
      w_eot_nxt = 1'b1;
      if (r_full) begin
        w_load = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    end else begin
      w_eot_nxt = 1'b0;
    end

    if (w_load) begin
      w_state_nxt     = ST_START;
      w_tx_nxt        = 1'b0;
      w_shift_nxt     = r_buf_data;
      w_bitcnt_nxt    = 3'd0;
      w_stop_half_nxt = 1'b0;
    end else begin
      w_shift_nxt     = w_shift_nxt;
    end
  end

  // Holding-buffer occupancy.
  always_comb begin
    if (w_accept) begin
      w_full_nxt = 1'b1;
    end else if (w_load) begin
      w_full_nxt = 1'b0;
    end else begin
      w_full_nxt = r_full;
    end
  end

  // FSM, shifter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_eot        <= 1'b0;
      r_shift      <= 8'd0;
      r_bitcnt     <= 3'd0;
      r_stop_half  <= 1'b0;
      r_psel_frame <= 1'b0;
      r_par        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tx        <= w_tx_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_eot       <= w_eot_nxt;
      r_shift     <= w_shift_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_stop_half <= w_stop_half_nxt;
      if (w_load) begin
        r_psel_frame <= r_buf_psel;
        r_par        <= even_parity(r_buf_data);
      end else begin
        r_psel_frame <= r_psel_frame;
        r_par        <= r_par;
      end
    end
  end

  // Holding buffer and ready flag.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_full     <= 1'b0;
      r_ready    <= 1'b1;
      r_buf_data <= 8'd0;
      r_buf_psel <= 1'b0;
    end else begin
      r_full  <= w_full_nxt;
      r_ready <= ~w_full_nxt;
      if (w_accept) begin
        r_buf_data <= din_i;
        r_buf_psel <= psel_i;
      end else begin
        r_buf_data <= r_buf_data;
        r_buf_psel <= r_buf_psel;
      end
    end
  end

endmodule

// File: tb/tb_rs232_tx.sv
// Bench for rs232_tx: table-driven frames, back-to-back, mid-frame reset and
// random frames checked cycle by cycle against an expected serial waveform.
module tb_rs232_tx;

`ifdef RS232_TX_TWO_STOP_EN
  localparam int XS = 1;
`else
  localparam int XS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [14:0] baud = 15'd4;
  logic        psel = 1'b0;
  logic [7:0]  din = 8'd0;
  logic        valid = 1'b0;
  logic        ready, tx, busy, eot;

  int checks = 0;
  int errors = 0;

  rs232_tx dut (
    .clk_i(clk), .rst_i(rst), .baud_i(baud), .psel_i(psel), .din_i(din),
    .valid_i(valid), .ready_o(ready), .tx_o(tx), .busy_o(busy), .eot_o(eot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] baud;
    logic        psel;
    logic [7:0]  din;
    int          cpb;
    logic        par;
    int          eot_cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Serial frame, bit 0 first: start, data LSB first, optional parity, stop(s).
  function automatic logic [11:0] mk_frame(input logic [7:0] d, input logic p, input logic par);
    logic [11:0] f;
    f = 12'hFFF;
    f[0] = 1'b0;
    f[8:1] = d;
    if (p) f[9] = par;
    return f;
  endfunction

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((ready !== 1'b1 || busy !== 1'b0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_idle_timeout: actual busy %0b required 0", nm, busy);
    end
  endtask

  task automatic run_frame(input string nm, input logic [14:0] b, input logic p,
                           input logic [7:0] d, input int cpb, input logic par, input int eot_cyc);
    logic [11:0] f;
    f = mk_frame(d, p, par);
    wait_idle(nm);
    baud = b; psel = p; din = d; valid = 1'b1;
    step();
    valid = 1'b0;
    din = 8'($urandom);
    psel = ~p;
    chk({nm, "_ready_after_accept"}, ready, 1'b0);
    chk({nm, "_tx_idle_c0"}, tx, 1'b1);
    for (int k = 1; k < eot_cyc; k++) begin
      step();
      chk({nm, "_tx"}, tx, f[(k-1)/cpb]);
      chk({nm, "_eot_low"}, eot, 1'b0);
      chk({nm, "_busy"}, busy, 1'b1);
      if (k == 1) chk({nm, "_ready_unload"}, ready, 1'b1);
    end
    step();
    chk({nm, "_eot_pulse"}, eot, 1'b1);
    chk({nm, "_tx_end"}, tx, 1'b1);
    step();
    chk({nm, "_eot_single"}, eot, 1'b0);
    chk({nm, "_busy_fall"}, busy, 1'b0);
    psel = p;
  endtask

  initial begin
    logic [11:0] f1, f2;
    int L;
    logic exp_tx;
    logic [14:0] rb;
    logic [7:0]  rd;
    logic        rp;
    int          rc;

    vecs[0] = '{15'd4, 1'b0, 8'h55, 4, 1'b0, 41 + 4*XS};
    vecs[1] = '{15'd4, 1'b1, 8'h03, 4, 1'b0, 45 + 4*XS};
    vecs[2] = '{15'd4, 1'b1, 8'h07, 4, 1'b1, 45 + 4*XS};
    vecs[3] = '{15'd0, 1'b0, 8'h81, 2, 1'b0, 21 + 2*XS};
    vecs[4] = '{15'd1, 1'b1, 8'h01, 2, 1'b1, 23 + 2*XS};
    vecs[5] = '{15'd2, 1'b1, 8'hFE, 2, 1'b1, 23 + 2*XS};
    vecs[6] = '{15'd5, 1'b0, 8'h00, 5, 1'b0, 51 + 5*XS};

    // Reset state.
    rst = 1'b0;
    repeat (3) step();
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_eot", eot, 1'b0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 7; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].baud, vecs[i].psel, vecs[i].din,
                vecs[i].cpb, vecs[i].par, vecs[i].eot_cyc);

    // Back-to-back frames with garbage offered while the buffer is full.
    wait_idle("b2b");
    L  = 3 * (10 + XS);
    f1 = mk_frame(8'hA5, 1'b0, 1'b0);
    f2 = mk_frame(8'h3C, 1'b0, 1'b0);
    baud = 15'd3; psel = 1'b0; din = 8'hA5; valid = 1'b1;
    step();
    valid = 1'b0;
    chk("b2b_ready_c0", ready, 1'b0);
    for (int c = 1; c <= 2*L + 2; c++) begin
      step();
      if (c <= L) exp_tx = f1[(c-1)/3];
      else if (c <= 2*L) exp_tx = f2[(c-L-1)/3];
      else exp_tx = 1'b1;
      chk("b2b_tx", tx, exp_tx);
      chk("b2b_eot", eot, (c == L+1) || (c == 2*L+1));
      if (c <= 2*L) chk("b2b_busy", busy, 1'b1);
      if (c == 2*L+2) chk("b2b_busy_fall", busy, 1'b0);
      chk("b2b_ready", ready, !(c >= 3 && c <= L));
      if (c == 2) begin din = 8'h3C; valid = 1'b1; end
      if (c == 3) valid = 1'b0;
      if (c >= 5 && c <= 20) begin din = 8'($urandom); valid = 1'b1; end
      if (c == 21) valid = 1'b0;
      if (c > L) din = 8'($urandom);
    end

    // Reset during din[3] aborts the frame without an eot pulse.
    wait_idle("rstmid");
    f1 = mk_frame(8'h5A, 1'b0, 1'b0);
    baud = 15'd8; psel = 1'b0; din = 8'h5A; valid = 1'b1;
    step();
    valid = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      step();
      chk("rstmid_tx", tx, f1[(c-1)/8]);
    end
    rst = 1'b0;
    step();
    chk("rstmid_tx_high", tx, 1'b1);
    chk("rstmid_ready", ready, 1'b1);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_eot", eot, 1'b0);
    rst = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      chk("rstmid_no_eot", eot, 1'b0);
      chk("rstmid_line_idle", tx, 1'b1);
    end
    run_frame("after_rst", 15'd8, 1'b1, 8'hC3, 8, 1'b0, 8*(11 + XS) + 1);

    // Random frames against the arithmetic frame model.
    for (int i = 0; i < 12; i++) begin
      rb = 15'($urandom_range(0, 6));
      rd = 8'($urandom);
      rp = 1'($urandom);
      rc = (rb < 15'd2) ? 2 : int'(rb);
      run_frame($sformatf("rnd%0d", i), rb, rp, rd, rc, 1'($countones(rd) % 2),
                rc * (10 + int'(rp) + XS) + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs232_tx.md
RS232_TX -- requirements
Module: rs232_tx

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-low reset, with ports as follows.
- clk_i  input  1  system clock; all state updates on its rising edge.
- rst_i  input  1  synchronous active-low reset.
- baud_i  input  15  bit period in clk_i cycles; values 0 and 1 are treated as 2.
- psel_i  input  1  1 = 8 data bits + parity bit; 0 = 8 data bits only.
- din_i  input  8  byte to transmit.
- valid_i  input  1  din_i is valid.
- ready_o  output  1  holding buffer empty; a byte can be accepted.
- tx_o  output  1  serial line; idle high.
- busy_o  output  1  a frame is on the line.
- eot_o  output  1  one-cycle pulse at the end of each frame.

Function
REQ-002 A transfer SHALL occur on a rising edge where valid_i=1 and ready_o=1; din_i and psel_i are then captured into a one-entry holding buffer.
- ready_o SHALL deassert on the next cycle and stay low until the FSM unloads the buffer.
REQ-003 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
- IDLE->START when the buffer is full.
- START->DATA after 1 bit period.
- DATA->PARITY after 8 bit periods if psel=1, otherwise DATA->STOP.
- PARITY->STOP after 1 bit period.
- STOP->START after 1 bit period if the buffer is full, otherwise STOP->IDLE.
REQ-004 On entering START, the FSM SHALL unload the buffer into a shift register.
- ready_o SHALL return high on the same edge.
- psel_i used for the frame is the value captured with the byte.
REQ-005 From IDLE, tx_o SHALL go low on the edge after the accepting edge (1-cycle latency).
REQ-006 tx_o SHALL be registered and carry, in order:
- start bit 0;
- din[0] through din[7] (LSB first);
- even parity (XOR of the 8 data bits) if psel=1;
- stop bit 1.
Each bit SHALL last exactly max(baud_i,2) cycles.
REQ-007 The bit-period counter SHALL restart at 0 on every entry to START, so frames are phase-aligned to their start.
- baud_i SHALL be sampled at frame start and held for the whole frame.
REQ-008 eot_o SHALL pulse high for exactly one cycle on the edge that ends the last stop-bit period.
REQ-009 When the buffer is full at that edge, the next start bit SHALL begin on the same edge, with no idle cycles between frames.
REQ-010 busy_o SHALL be 1 in every state except IDLE.
REQ-011 valid_i while ready_o=0 SHALL be ignored, and din_i changes during a frame SHALL NOT affect it.

Reset
REQ-012 While rst_i=0 at a rising edge, outputs and state SHALL take these values: tx_o=1, ready_o=1, busy_o=0, eot_o=0, FSM=IDLE, buffer empty, counters 0.
REQ-013 A reset mid-frame SHALL abort the frame.
- tx_o SHALL be high from the reset edge onward.
- No eot_o pulse SHALL be generated.

Configuration
REQ-014 When the macro RS232_TX_TWO_STOP_EN is defined, STOP SHALL last 2 bit periods, and eot_o SHALL pulse at the end of the second period.
- When it is undefined, STOP SHALL last 1 bit period.

Structure
REQ-015 The shared package rs232_pkg SHALL hold:
- the FSM state encoding (shared with the receiver FSM);
- the data width constant (8);
- the baud width constant (15);
- the minimum bit period constant (2).
REQ-016 Bit timing SHALL be in one sub-module, baud_gen_tx. It takes a restart input and baud_i, and emits a one-cycle tick at the end of each bit period. The FSM, shift register, parity and buffer SHALL stay in rs232_tx.

Verification
REQ-017 The bench SHALL cover these scenarios:
- baud_i=4, psel_i=0, din_i=0x55 accepted at cycle 0 -> tx_o low from cycle 1, then 1,0,1,0,1,0,1,0,1, each for 4 cycles. eot_o pulses at cycle 41, and busy_o falls after it.
- baud_i=4, psel_i=1, din_i=0x03 -> parity bit 0. With din_i=0x07 -> parity bit 1. Frame is 11 bits (44 cycles).
- baud_i=3, bytes 0xA5 and 0x3C offered back-to-back -> second accepted while the first is on the line. Second start bit begins on the same edge as the first eot_o pulse. ready_o is low while the buffer is full.
- baud_i=8, rst_i=0 for one cycle during bit din[3] -> tx_o=1 and ready_o=1 from the reset edge, no eot_o pulse. The next byte produces a full correct frame.
- baud_i=0 and baud_i=1 -> every bit lasts 2 cycles.
- RS232_TX_TWO_STOP_EN defined, baud_i=4, psel_i=0 -> stop high for 8 cycles, and eot_o pulses at cycle 45 after acceptance.
